// File: rtl/recorder_pkg.sv
// recorder_pkg: shared widths, limits and state encoding for the audio recorder controller.
//   ADDR_W   - SRAM word address width
//   DATA_W   - sample / SRAM data width
//   RATE_W   - width of the playback rate factor f (1..8)
//   REP_W    - width of the slow-mode repeat counter (0..7)
//   MAX_ADDR - highest SRAM address; a write here ends the recording
//   state_e  - controller state, encoding as seen on o_state
package recorder_pkg;

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned RATE_W = 4;
  localparam int unsigned REP_W  = 3;

  localparam logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}};

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StHold  = 3'd1,
    StRec   = 3'd2,
    StPlay  = 3'd3,
    StPause = 3'd4
  } state_e;

endpackage

// File: rtl/play_rate_gen.sv
// play_rate_gen: combinational playback address stepper, evaluated once per output sample.
//   addr_i      - address of the sample just output
//   rep_i       - number of repeats of this sample already completed (slow mode)
//   rate_i      - rate factor f (1..8)
//   fast_i      - 1: skip f addresses per output, 0: repeat each sample f times
//   end_addr_i  - last address of the recording
//   next_addr_o - address for the next output
//   next_rep_o  - repeat count for the next output
//   done_o      - playback has run past the end of the recording
module play_rate_gen
  import recorder_pkg::*;
(
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [REP_W-1:0]  rep_i,
  input  logic [RATE_W-1:0] rate_i,
  input  logic              fast_i,
  input  logic [ADDR_W-1:0] end_addr_i,
  output logic [ADDR_W-1:0] next_addr_o,
  output logic [REP_W-1:0]  next_rep_o,
  output logic              done_o
);

  // One spare bit so that stepping past MAX_ADDR cannot wrap back into the recording.
  logic [ADDR_W:0] sum;
  logic            advance;

  always_comb begin
    sum        = {1'b0, addr_i};
    next_rep_o = '0;
    advance    = 1'b0;
    if (fast_i) begin
      sum     = {1'b0, addr_i} + {{(ADDR_W + 1 - RATE_W){1'b0}}, rate_i};
      advance = 1'b1;
    end else if (({1'b0, rep_i} + 4'd1) >= rate_i) begin
      // ">=" rather than "==" so a rate lowered mid-sample moves on at once.
      sum     = {1'b0, addr_i} + (ADDR_W + 1)'(1);
      advance = 1'b1;
    end else begin
      next_rep_o = rep_i + REP_W'(1);
    end
    next_addr_o = sum[ADDR_W-1:0];
    done_o      = advance && (sum > {1'b0, end_addr_i});
  end

endmodule

// File: rtl/recorder_ctrl.sv
// recorder_ctrl: record/playback controller between a sample codec and an external SRAM.
//   i_clk, i_rst                - clock, asynchronous active-high reset
//   i_key_rec/play/pause/stop   - one-cycle command pulses (stop > pause > rec > play)
//   i_sw_fast, i_sw_speed       - playback mode and rate factor f = i_sw_speed + 1
//   i_sample_tick, i_adc_data   - codec sample strobe and record sample
//   i_sram_rdata                - SRAM read data for o_sram_addr (combinational)
//   o_state                     - 0 idle, 1 hold, 2 record, 3 play, 4 pause
//   o_sram_addr/we/wdata        - SRAM port
//   o_dac_data, o_dac_valid     - playback sample and its one-cycle strobe
//   o_end_addr                  - last address written by the latest recording
// A tick is registered into a one-cycle write or output strobe; the address only moves at the
// end of that strobe cycle, so the strobe always presents the address it belongs to.
module recorder_ctrl
  import recorder_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_key_rec,
  input  logic              i_key_play,
  input  logic              i_key_pause,
  input  logic              i_key_stop,
  input  logic              i_sw_fast,
  input  logic [2:0]        i_sw_speed,
  input  logic              i_sample_tick,
  input  logic [DATA_W-1:0] i_adc_data,
  input  logic [DATA_W-1:0] i_sram_rdata,
  output logic [2:0]        o_state,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_sram_we,
  output logic [DATA_W-1:0] o_sram_wdata,
  output logic [DATA_W-1:0] o_dac_data,
  output logic              o_dac_valid,
  output logic [ADDR_W-1:0] o_end_addr
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [REP_W-1:0]    rep_q, rep_d;
  logic [RATE_W-1:0]   rate_q, rate_d;
  logic                fast_q, fast_d;
  logic                recorded_q, recorded_d;
  logic [ADDR_W-1:0]   end_q, end_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                dv_q, dv_d;
  logic [DATA_W-1:0]   dac_q, dac_d;

  logic                k_stop, k_pause, k_rec, k_play;
  logic                go_idle;
  logic [ADDR_W-1:0]   gen_addr;
  logic [REP_W-1:0]    gen_rep;
  logic                gen_done;

  // Only the highest-priority key pressed this cycle is seen.
  assign k_stop  = i_key_stop;
  assign k_pause = !i_key_stop && i_key_pause;
  assign k_rec   = !i_key_stop && !i_key_pause && i_key_rec;
  assign k_play  = !i_key_stop && !i_key_pause && !i_key_rec && i_key_play;

  play_rate_gen u_rate (
    .addr_i      (addr_q),
    .rep_i       (rep_q),
    .rate_i      (rate_q),
    .fast_i      (fast_q),
    .end_addr_i  (end_q),
    .next_addr_o (gen_addr),
    .next_rep_o  (gen_rep),
    .done_o      (gen_done)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rep_d      = rep_q;
    rate_d     = rate_q;
    fast_d     = fast_q;
    recorded_d = recorded_q;
    end_d      = end_q;
    we_d       = 1'b0;
    wdata_d    = wdata_q;
    dv_d       = 1'b0;
    dac_d      = dac_q;
    go_idle    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (k_rec) begin
          state_d = StRec;
          addr_d  = '0;
        end else if (k_play && recorded_q) begin
          state_d = StPlay;
          addr_d  = '0;
        end
      end
      StRec: begin
        // The write strobe completes even if a key arrives in the same cycle.
        if (we_q) begin
          end_d      = addr_q;
          recorded_d = 1'b1;
          if (addr_q == MAX_ADDR) go_idle = 1'b1;
          else                    addr_d  = addr_q + ADDR_W'(1);
        end
        if (k_stop)                    go_idle = 1'b1;
        else if (k_pause && !go_idle)  state_d = StHold;
        if (!go_idle && (state_d == StRec) && i_sample_tick) begin
          we_d    = 1'b1;
          wdata_d = i_adc_data;
        end
      end
      StHold: begin
        if (k_stop)                go_idle = 1'b1;
        else if (k_pause || k_rec) state_d = StRec;
      end
      StPlay: begin
        if (dv_q) begin
          addr_d = gen_addr;
          rep_d  = gen_rep;
          if (gen_done) go_idle = 1'b1;
        end
        if (k_stop)                    go_idle = 1'b1;
        else if (k_pause && !go_idle)  state_d = StPause;
        if (!go_idle && (state_d == StPlay) && i_sample_tick) begin
          dv_d   = 1'b1;
          dac_d  = i_sram_rdata;
          // Rate and mode are latched per tick and used when this output retires.
          rate_d = {1'b0, i_sw_speed} + RATE_W'(1);
          fast_d = i_sw_fast;
        end
      end
      StPause: begin
        if (k_stop)                 go_idle = 1'b1;
        else if (k_pause || k_play) state_d = StPlay;
      end
      default: go_idle = 1'b1;
    endcase

    if (go_idle) begin
      state_d = StIdle;
      addr_d  = '0;
      rep_d   = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      rep_q      <= '0;
      rate_q     <= '0;
      fast_q     <= 1'b0;
      recorded_q <= 1'b0;
      end_q      <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      dv_q       <= 1'b0;
      dac_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rep_q      <= rep_d;
      rate_q     <= rate_d;
      fast_q     <= fast_d;
      recorded_q <= recorded_d;
      end_q      <= end_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      dv_q       <= dv_d;
      dac_q      <= dac_d;
    end
  end

  assign o_state      = state_q;
  assign o_sram_addr  = addr_q;
  assign o_sram_we    = we_q;
  assign o_sram_wdata = wdata_q;
  assign o_dac_data   = dac_q;
  assign o_dac_valid  = dv_q;
  assign o_end_addr   = end_q;

endmodule

// File: tb/tb_recorder_ctrl.sv
// tb_recorder_ctrl: self-checking bench for recorder_ctrl with an SRAM model and a sample-level
// reference model of recording and playback.
module tb_recorder_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_rec, key_play, key_pause, key_stop;
  logic        sw_fast;
  logic [2:0]  sw_speed;
  logic        sample_tick;
  logic [15:0] adc_data;
  logic [15:0] sram_rdata;
  logic [2:0]  state;
  logic [19:0] sram_addr;
  logic        sram_we;
  logic [15:0] sram_wdata;
  logic [15:0] dac_data;
  logic        dac_valid;
  logic [19:0] end_addr;

  int checks   = 0;
  int failures = 0;

  recorder_ctrl dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_key_rec     (key_rec),
    .i_key_play    (key_play),
    .i_key_pause   (key_pause),
    .i_key_stop    (key_stop),
    .i_sw_fast     (sw_fast),
    .i_sw_speed    (sw_speed),
    .i_sample_tick (sample_tick),
    .i_adc_data    (adc_data),
    .i_sram_rdata  (sram_rdata),
    .o_state       (state),
    .o_sram_addr   (sram_addr),
    .o_sram_we     (sram_we),
    .o_sram_wdata  (sram_wdata),
    .o_dac_data    (dac_data),
    .o_dac_valid   (dac_valid),
    .o_end_addr    (end_addr)
  );

  always #5 clk = ~clk;

  // SRAM model; recordings in this bench stay below 1024 words.
  logic [15:0] mem [0:1023];
  assign sram_rdata = mem[sram_addr[9:0]];
  always @(posedge clk) if (sram_we) mem[sram_addr[9:0]] <= sram_wdata;

  // Observed traffic.
  int wa[$];
  int wd[$];
  int dq[$];
  int bad_we = 0;
  int bad_dv = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (sram_we) begin
        wa.push_back(int'(sram_addr));
        wd.push_back(int'(sram_wdata));
        if (state != 3'd2) bad_we++;
      end
      if (dac_valid) begin
        dq.push_back(int'(dac_data));
        if (state != 3'd3) bad_dv++;
      end
    end
  end

  // Reference: the samples of the latest recording, in address order.
  int rec_data[$];
  int model_end = 0;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic clear_obs();
    wa.delete();
    wd.delete();
    dq.delete();
  endtask

  task automatic tick(input int d);
    @(negedge clk);
    sample_tick = 1'b1;
    adc_data    = 16'(d);
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic press(input logic r, input logic p, input logic pa, input logic s);
    @(negedge clk);
    key_rec = r; key_play = p; key_pause = pa; key_stop = s;
    @(negedge clk);
    key_rec = 1'b0; key_play = 1'b0; key_pause = 1'b0; key_stop = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++; if (state !== 3'd0) begin failures++;
      $display("FAIL reset_state got=%0d want=0", state); end
    checks++; if (sram_we !== 1'b0 || dac_valid !== 1'b0) begin failures++;
      $display("FAIL reset_strobes got we=%0b dv=%0b want 0 0", sram_we, dac_valid); end
    checks++; if (sram_addr !== 20'd0 || end_addr !== 20'd0) begin failures++;
      $display("FAIL reset_addr got addr=%0h end=%0h want 0 0", sram_addr, end_addr); end
    checks++; if (dac_data !== 16'd0 || sram_wdata !== 16'd0) begin failures++;
      $display("FAIL reset_data got dac=%0h wdata=%0h want 0 0", dac_data, sram_wdata); end
    clear_obs();
    press(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (state !== 3'd0) begin failures++;
      $display("FAIL play_without_recording got=%0d want=0", state); end
    tick(16'h1234);
    checks++; if (dq.size() != 0) begin failures++;
      $display("FAIL idle_no_output got=%0d want=0", dq.size()); end
  endtask

  task automatic do_record(input string name, input int n);
    clear_obs();
    press(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (state !== 3'd2) begin failures++;
      $display("FAIL %s_enter got=%0d want=2", name, state); end
    for (int i = 0; i < n; i++) tick(rec_data[i]);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    model_end = n - 1;
    checks++; if (state !== 3'd0) begin failures++;
      $display("FAIL %s_stop got=%0d want=0", name, state); end
    checks++; if (wa.size() != n) begin failures++;
      $display("FAIL %s_count got=%0d want=%0d", name, wa.size(), n); end
    for (int i = 0; i < n && i < wa.size(); i++) begin
      checks++; if (wa[i] != i || wd[i] != rec_data[i]) begin failures++;
        $display("FAIL %s_write%0d got addr=%0h data=%0h want %0h %0h",
                 name, i, wa[i], wd[i], i, rec_data[i]); end
    end
    checks++; if (end_addr !== 20'(model_end)) begin failures++;
      $display("FAIL %s_end got=%0h want=%0h", name, end_addr, model_end); end
  endtask

  task automatic test_record_basic();
    rec_data = '{1, 2, 3, 4, 5};
    do_record("rec5", 5);
  endtask

  task automatic test_record_random();
    int n;
    n = $urandom_range(3, 12);
    rec_data.delete();
    for (int i = 0; i < n; i++) rec_data.push_back(int'($urandom_range(0, 65535)));
    do_record("rec_rand", n);
  endtask

  task automatic check_outputs(input string name, input int exp[$]);
    checks++; if (state !== 3'd0) begin failures++;
      $display("FAIL %s_final_state got=%0d want=0", name, state); end
    checks++; if (dq.size() != exp.size()) begin failures++;
      $display("FAIL %s_count got=%0d want=%0d", name, dq.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < dq.size(); i++) begin
      checks++; if (dq[i] != exp[i]) begin failures++;
        $display("FAIL %s_out%0d got=%0h want=%0h", name, i, dq[i], exp[i]); end
    end
  endtask

  task automatic test_play(input string name, input logic fast, input int f);
    int exp[$];
    clear_obs();
    sw_fast  = fast;
    sw_speed = 3'(f - 1);
    if (fast) for (int a = 0; a <= model_end; a += f) exp.push_back(rec_data[a]);
    else for (int a = 0; a <= model_end; a++) repeat (f) exp.push_back(rec_data[a]);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (state !== 3'd3) begin failures++;
      $display("FAIL %s_enter got=%0d want=3", name, state); end
    for (int i = 0; i < exp.size(); i++) begin
      if (i == exp.size() - 1) begin
        checks++; if (state !== 3'd3) begin failures++;
          $display("FAIL %s_early_end got=%0d want=3", name, state); end
      end
      tick(0);
    end
    tick(0);
    check_outputs(name, exp);
  endtask

  // Rate changes on every tick; expected sample follows the address/repeat rules directly.
  task automatic test_play_random(input logic fast);
    int exp[$];
    int maddr, mrep, f, n;
    clear_obs();
    sw_fast = fast;
    maddr = 0; mrep = 0; n = 0;
    press(1'b0, 1'b1, 1'b0, 1'b0);
    while (maddr <= model_end && n < 200) begin
      f = $urandom_range(1, 8);
      sw_speed = 3'(f - 1);
      tick(0);
      exp.push_back(rec_data[maddr]);
      if (fast) maddr += f;
      else if (mrep + 1 >= f) begin maddr++; mrep = 0; end
      else mrep++;
      n++;
    end
    tick(0);
    check_outputs(fast ? "rand_fast" : "rand_slow", exp);
  endtask

  task automatic test_hold();
    clear_obs();
    press(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (state !== 3'd2) begin failures++;
      $display("FAIL hold_rec1 got=%0d want=2", state); end
    tick(16'h10); tick(16'h11);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (state !== 3'd1) begin failures++;
      $display("FAIL hold_enter got=%0d want=1", state); end
    tick(16'h20); tick(16'h21); tick(16'h22);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (state !== 3'd2) begin failures++;
      $display("FAIL hold_resume got=%0d want=2", state); end
    tick(16'h12);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    rec_data = '{16'h10, 16'h11, 16'h12};
    model_end = 2;
    checks++; if (wa.size() != 3) begin failures++;
      $display("FAIL hold_count got=%0d want=3", wa.size()); end
    for (int i = 0; i < 3 && i < wa.size(); i++) begin
      checks++; if (wa[i] != i || wd[i] != rec_data[i]) begin failures++;
        $display("FAIL hold_write%0d got addr=%0h data=%0h want %0h %0h",
                 i, wa[i], wd[i], i, rec_data[i]); end
    end
    checks++; if (end_addr !== 20'd2) begin failures++;
      $display("FAIL hold_end got=%0h want=2", end_addr); end
  endtask

  task automatic test_pause_resume();
    int exp[$];
    exp = '{16'h10, 16'h10, 16'h11, 16'h11, 16'h12, 16'h12};
    clear_obs();
    sw_fast = 1'b0; sw_speed = 3'd1;
    press(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) tick(0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (state !== 3'd4) begin failures++;
      $display("FAIL pause_enter got=%0d want=4", state); end
    tick(0); tick(0);
    checks++; if (dq.size() != 3) begin failures++;
      $display("FAIL pause_silent got=%0d want=3", dq.size()); end
    press(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (state !== 3'd3) begin failures++;
      $display("FAIL pause_resume got=%0d want=3", state); end
    repeat (4) tick(0);
    check_outputs("pause_resume", exp);
  endtask

  task automatic test_priority();
    clear_obs();
    sw_fast = 1'b1; sw_speed = 3'd0;
    press(1'b0, 1'b1, 1'b0, 1'b0);
    tick(0); tick(0);
    checks++; if (sram_addr !== 20'd2) begin failures++;
      $display("FAIL prio_play_addr got=%0h want=2", sram_addr); end
    press(1'b0, 1'b0, 1'b1, 1'b1);
    checks++; if (state !== 3'd0 || sram_addr !== 20'd0) begin failures++;
      $display("FAIL prio_pause_stop got state=%0d addr=%0h want 0 0", state, sram_addr); end
    press(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (state !== 3'd2) begin failures++;
      $display("FAIL prio_rec_over_play got=%0d want=2", state); end
    press(1'b1, 1'b0, 1'b0, 1'b1);
    checks++; if (state !== 3'd0) begin failures++;
      $display("FAIL prio_stop_over_rec got=%0d want=0", state); end
    clear_obs();
    @(negedge clk);
    key_rec = 1'b1; sample_tick = 1'b1; adc_data = 16'hBEEF;
    @(negedge clk);
    key_rec = 1'b0; sample_tick = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (state !== 3'd2 || wa.size() != 0) begin failures++;
      $display("FAIL rec_tick_same_cycle got state=%0d writes=%0d want 2 0", state, wa.size()); end
    press(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (end_addr !== 20'(model_end)) begin failures++;
      $display("FAIL prio_end_kept got=%0h want=%0h", end_addr, model_end); end
  endtask

  task automatic test_reset_mid_play();
    clear_obs();
    sw_fast = 1'b0; sw_speed = 3'd0;
    press(1'b0, 1'b1, 1'b0, 1'b0);
    tick(0);
    @(negedge clk);
    sample_tick = 1'b1;
    @(posedge clk);
    #2;
    sample_tick = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (state !== 3'd0 || sram_addr !== 20'd0 || end_addr !== 20'd0) begin failures++;
      $display("FAIL async_reset_addr got state=%0d addr=%0h end=%0h want 0 0 0",
               state, sram_addr, end_addr); end
    checks++; if (dac_valid !== 1'b0 || dac_data !== 16'd0) begin failures++;
      $display("FAIL async_reset_dac got dv=%0b data=%0h want 0 0", dac_valid, dac_data); end
    @(negedge clk);
    rst = 1'b0;
    clear_obs();
    press(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (state !== 3'd0) begin failures++;
      $display("FAIL play_after_reset got=%0d want=0", state); end
    tick(0);
    checks++; if (dq.size() != 0) begin failures++;
      $display("FAIL play_after_reset_out got=%0d want=0", dq.size()); end
  endtask

  task automatic test_qualifiers();
    checks++; if (bad_we != 0) begin failures++;
      $display("FAIL we_outside_rec got=%0d want=0", bad_we); end
    checks++; if (bad_dv != 0) begin failures++;
      $display("FAIL dv_outside_play got=%0d want=0", bad_dv); end
  endtask

  initial begin
    rst = 1'b1;
    key_rec = 1'b0; key_play = 1'b0; key_pause = 1'b0; key_stop = 1'b0;
    sw_fast = 1'b0; sw_speed = 3'd0;
    sample_tick = 1'b0; adc_data = 16'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_record_basic();
    test_play("slow_f3", 1'b0, 3);
    test_play("fast_f2", 1'b1, 2);
    test_play("fast_f8", 1'b1, 8);
    test_hold();
    test_pause_resume();
    test_priority();
    repeat (3) begin
      test_record_random();
      test_play_random(1'b0);
      test_play_random(1'b1);
    end
    test_reset_mid_play();
    test_qualifiers();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
